// File: rtl/uart_transmitter_if.sv
// Host-side bundle for uart_transmitter.
//   tx_data              host -> tx  byte to send, sampled when a start is accepted
//   tx_start             host -> tx  start request, rising-edge detected
//   tx_complete_del_flag host -> tx  level clear for tx_complete_flag
//   TXD                  tx -> host  serial line, idles high
//   tx_complete_flag     tx -> host  sticky frame-done flag
//   tx_busy              tx -> host  frame in progress
// master = host side, slave = transmitter side.
interface uart_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_complete_del_flag;
  logic       TXD;
  logic       tx_complete_flag;
  logic       tx_busy;

  modport master (
    output tx_data, tx_start, tx_complete_del_flag,
    input  TXD, tx_complete_flag, tx_busy
  );

  modport slave (
    input  tx_data, tx_start, tx_complete_del_flag,
    output TXD, tx_complete_flag, tx_busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity,
// STOP_BITS stop bits. All outputs registered.
// Ports:
//   tx_clk   single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_transmitter_if.slave (tx_data, tx_start, tx_complete_del_flag
//            in; TXD, tx_complete_flag, tx_busy out)
// Parameters: CLKS_PER_BIT (1..65535), STOP_BITS (1 or 2), PARITY_ODD (0/1).
// Build option: define TX_PARITY_EN to insert a parity bit between the data
// bits and the stop bit(s); PARITY_ODD selects odd parity.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             tx_clk,
  input  logic             reset_n,
  uart_transmitter_if.slave bus
);

  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("CLKS_PER_BIT out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic        start_prev_q, start_prev_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        flag_q, flag_d;
  logic        baud_tick;
  logic        done;
`ifdef TX_PARITY_EN
  logic        par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    done         = 1'b0;
    start_prev_d = bus.tx_start;
`ifdef TX_PARITY_EN
    par_d        = par_q;
`endif
    baud_tick = (baud_q == BAUD_MAX);
    baud_d    = baud_tick ? 16'd0 : baud_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (bus.tx_start && !start_prev_q) begin
          state_d = START;
          shift_d = bus.tx_data;
          bit_d   = 3'd0;
          stop_d  = 1'b0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef TX_PARITY_EN
          par_d   = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: if (baud_tick) begin
        state_d = DATA;
        txd_d   = shift_q[0];
      end
      DATA: if (baud_tick) begin
        if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
          state_d = PARITY;
          txd_d   = par_q;
`else
          state_d = STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          // next bit goes out now, so drive shift_q[1] alongside the shift
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          txd_d   = shift_q[1];
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (baud_tick) begin
        state_d = STOP;
        txd_d   = 1'b1;
      end
`endif
      STOP: if (baud_tick) begin
        if (stop_q == STOP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done    = 1'b1;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // set beats a coincident clear
    flag_d = done | (flag_q & ~bus.tx_complete_del_flag);
  end

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      start_prev_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      flag_q       <= 1'b0;
`ifdef TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      start_prev_q <= start_prev_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      flag_q       <= flag_d;
`ifdef TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.TXD              = txd_q;
  assign bus.tx_busy          = busy_q;
  assign bus.tx_complete_flag = flag_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level reference model compared every
// cycle, plus literal checks on the 8'h2F frame, clear handshake, busy
// ignore, back-to-back start, reset abort and a randomized soak.
module tb_uart_transmitter;
  localparam int C  = 16;
  localparam int SB = 1;
`ifdef TX_PARITY_EN
  localparam int          PB        = 1;
  localparam logic [11:0] LIT       = 12'h65E;
  localparam int          FRAME_LIT = 176;
`else
  localparam int          PB        = 0;
  localparam logic [11:0] LIT       = 12'h25E;
  localparam int          FRAME_LIT = 160;
`endif
  localparam int NB    = 10 + SB - 1 + PB;
  localparam int FRAME = NB * C;

  logic tx_clk  = 1'b0;
  logic reset_n = 1'b1;
  bit   chk_en  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  uart_transmitter_if bus ();

  uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
    .tx_clk (tx_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 tx_clk = ~tx_clk;

  // Model: a frame is a list of NB line bits; cnt = cycles since accept.
  typedef struct packed {
    logic        busy;
    logic        flag;
    logic        txd;
    logic        prev;
    int          cnt;
    logic [11:0] bits;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.busy = 1'b0; r.flag = 1'b0; r.txd = 1'b1; r.prev = 1'b0;
    r.cnt = 0; r.bits = '1;
    return r;
  endfunction

  function automatic logic [11:0] frame_bits(input logic [7:0] d);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
`ifdef TX_PARITY_EN
    b[9] = ^d;
`endif
    return b;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input logic st,
                                input logic [7:0] d, input logic del);
    mdl_t n;
    logic set;
    n = cur;
    set = 1'b0;
    if (cur.busy) begin
      n.cnt = cur.cnt + 1;
      if (n.cnt == FRAME) begin n.busy = 1'b0; set = 1'b1; end
    end else if (st && !cur.prev) begin
      n.busy = 1'b1; n.cnt = 0; n.bits = frame_bits(d);
    end
    n.prev = st;
    n.flag = set ? 1'b1 : (del ? 1'b0 : cur.flag);
    n.txd  = n.busy ? n.bits[n.cnt / C] : 1'b1;
    return n;
  endfunction

  always @(posedge tx_clk or negedge reset_n)
    if (!reset_n) m <= mdl_rst();
    else          m <= step(m, bus.tx_start, bus.tx_data, bus.tx_complete_del_flag);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge tx_clk) if (chk_en) begin
    #1;
    check("mdl_txd",  bus.TXD,              m.txd);
    check("mdl_busy", bus.tx_busy,          m.busy);
    check("mdl_flag", bus.tx_complete_flag, m.flag);
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.tx_busy && n < 2000) begin @(posedge tx_clk); #1; n++; end
    check({tag, "_idle_timeout"}, bus.tx_busy, 0);
  endtask

  // Sends d with tx_start held 5 cycles; samples each bit mid-period,
  // counts busy cycles and records the flag at the busy-fall edge.
  task automatic send(input logic [7:0] d, input bit inject, input string tag);
    logic [11:0] got;
    int nbusy;
    logic fall_flag;
    got = '0; nbusy = 0; fall_flag = 1'b0;
    @(negedge tx_clk);
    bus.tx_data = d;
    bus.tx_start = 1'b1;
    fork
      begin
        repeat (5) @(negedge tx_clk);
        bus.tx_start = 1'b0;
        if (inject) begin
          repeat (40) @(negedge tx_clk);
          bus.tx_data = 8'hA5;
          bus.tx_start = 1'b1;
          repeat (3) @(negedge tx_clk);
          bus.tx_start = 1'b0;
        end
      end
      begin
        @(posedge tx_clk); #1;
        repeat (C / 2) @(posedge tx_clk);
        #1;
        for (int i = 0; i < NB; i++) begin
          got[i] = bus.TXD;
          repeat (C) @(posedge tx_clk);
          #1;
        end
      end
      begin
        @(posedge tx_clk); #1;
        while (bus.tx_busy && nbusy < 1000) begin
          nbusy++;
          @(posedge tx_clk); #1;
        end
        fall_flag = bus.tx_complete_flag;
      end
    join
    check({tag, "_bits"},     got,       LIT);
    check({tag, "_busy_len"}, nbusy,     FRAME_LIT);
    check({tag, "_flag"},     fall_flag, 1);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    bus.tx_complete_del_flag = 1'b0;
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;
    check("rst_txd",  bus.TXD,              1);
    check("rst_busy", bus.tx_busy,          0);
    check("rst_flag", bus.tx_complete_flag, 0);
    @(negedge tx_clk) reset_n = 1'b1;
    repeat (20) @(posedge tx_clk);
    #1;
    check("idle_txd",  bus.TXD,     1);
    check("idle_busy", bus.tx_busy, 0);

    // single frame
    send(8'h2F, 1'b0, "frame");

    // clear handshake
    @(negedge tx_clk) bus.tx_complete_del_flag = 1'b1;
    @(posedge tx_clk); #1;
    check("clear", bus.tx_complete_flag, 0);
    @(negedge tx_clk) bus.tx_complete_del_flag = 1'b0;

    // start edge with 8'hA5 mid-frame is ignored
    send(8'h2F, 1'b1, "ignore");
    begin
      int n;
      n = 0;
      repeat (200) begin @(posedge tx_clk); #1; if (bus.tx_busy) n++; end
      check("no_second_frame", n, 0);
    end

    // set and clear on the same edge: set wins, then clear takes effect
    @(negedge tx_clk) bus.tx_complete_del_flag = 1'b1;
    send(8'h2F, 1'b0, "set_wins");
    check("clear_after_set", bus.tx_complete_flag, 0);
    @(negedge tx_clk) bus.tx_complete_del_flag = 1'b0;

    // back-to-back: new edge on the first idle cycle
    @(negedge tx_clk);
    bus.tx_data = 8'($urandom);
    bus.tx_start = 1'b1;
    @(negedge tx_clk) bus.tx_start = 1'b0;
    @(posedge tx_clk); #1;
    wait_idle("b2b1");
    @(negedge tx_clk) bus.tx_start = 1'b1;
    @(posedge tx_clk); #1;
    check("b2b_busy", bus.tx_busy, 1);
    check("b2b_txd",  bus.TXD,     0);
    @(negedge tx_clk) bus.tx_start = 1'b0;
    wait_idle("b2b2");

    // reset during data bit 3
    @(negedge tx_clk);
    bus.tx_data = 8'($urandom);
    bus.tx_start = 1'b1;
    @(posedge tx_clk); #1;
    bus.tx_start = 1'b0;
    repeat (4 * C + C / 2) @(posedge tx_clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort_txd",  bus.TXD,     1);
    check("abort_busy", bus.tx_busy, 0);
    @(negedge tx_clk) reset_n = 1'b1;
    repeat (3) @(posedge tx_clk);
    send(8'h2F, 1'b0, "post_abort");

    // randomized soak
    repeat (3000) begin
      @(negedge tx_clk);
      bus.tx_start = ($urandom_range(0, 5) == 0);
      bus.tx_data = 8'($urandom);
      bus.tx_complete_del_flag = ($urandom_range(0, 30) == 0);
    end
    @(negedge tx_clk);
    bus.tx_start = 1'b0;
    bus.tx_complete_del_flag = 1'b0;
    @(posedge tx_clk); #1;
    wait_idle("final");
    repeat (2) @(posedge tx_clk);
    #2;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
